shift_register_unload: RTL and testbench

Serial-in/parallel-out receiver that reassembles N-bit words from a serial bit stream sent LSB-first by a right-shifting parallel-load transmitter. It is the receiving end of the team's serial link between register blocks. It frames words with a bit counter, holds each completed word in an output register, and hands it off through a valid/ready handshake. Lost words are flagged with a sticky overrun bit.

---
 rtl/link_pkg.sv | 8 +
 rtl/sipo_shift_core.sv | 43 ++++
 rtl/shift_register_unload.sv | 52 +++++
 tb/tb_shift_register_unload.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared constants for the serial register-block link.
// Both transmitter and receiver import this to agree on width.
package link_pkg;

    localparam int LINK_W  = 4;
    localparam int LINK_CW = $clog2(LINK_W);

endpackage

// File: rtl/sipo_shift_core.sv
// Serial-in shift register with bit counter framing.
// Emits a one-cycle word_done pulse alongside the completed word.
module sipo_shift_core
    import link_pkg::*;
#(
    parameter int N = LINK_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         si,
    input  logic         shift_en,
    input  logic         clr,
    output logic [N-1:0] word,
    output logic         word_done,
    output logic         busy
);

    localparam int CW = $clog2(N);

    logic [N-1:0]  sh;
    logic [CW-1:0] cnt;
    logic          last;

    assign last      = (cnt == CW'(N - 1));
    assign word      = {si, sh[N-1:1]};
    assign word_done = shift_en && !clr && !reset && last;
    assign busy      = (cnt != '0);

    // Shift in LSB-first bits; clr re-aligns the frame and wins over a strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sh  <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            sh  <= word;
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_register_unload.sv
// Link receiver: reassembles serial words and hands them off via valid/ready.
// Words completing while the previous one is still unconsumed set sticky overrun.
module shift_register_unload
    import link_pkg::*;
#(
    parameter int N = LINK_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         SI,
    input  logic         shift_en,
    input  logic         clr,
    input  logic         ready,
    output logic [N-1:0] Q,
    output logic         valid,
    output logic         busy,
    output logic         overrun
);

    logic [N-1:0] word;
    logic         word_done;

    sipo_shift_core #(.N(N)) u_core (
        .clk       (clk),
        .reset     (reset),
        .si        (SI),
        .shift_en  (shift_en),
        .clr       (clr),
        .word      (word),
        .word_done (word_done),
        .busy      (busy)
    );

    // Hold register and handshake; a same-edge accept makes room for a new word.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q       <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (word_done) begin
            if (!valid || ready) begin
                Q     <= word;
                valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_register_unload.sv
// Directed bench for the serial link receiver.
// Linear stimulus with hand-computed expectations checked by assertions.
module tb_shift_register_unload;

    logic       clk;
    logic       reset;
    logic       SI;
    logic       shift_en;
    logic       clr;
    logic       ready;
    logic [3:0] Q;
    logic       valid;
    logic       busy;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    shift_register_unload #(.N(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .SI       (SI),
        .shift_en (shift_en),
        .clr      (clr),
        .ready    (ready),
        .Q        (Q),
        .valid    (valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic b);
        SI       = b;
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
        SI       = 1'b0;
    endtask

    task automatic outs(input string tag, input logic [3:0] q, input logic v,
                        input logic b, input logic o);
        chk({tag, ".Q"}, {4'h0, Q}, {4'h0, q});
        chk({tag, ".valid"}, {7'h0, valid}, {7'h0, v});
        chk({tag, ".busy"}, {7'h0, busy}, {7'h0, b});
        chk({tag, ".overrun"}, {7'h0, overrun}, {7'h0, o});
    endtask

    initial begin
        reset    = 1'b1;
        SI       = 1'b0;
        shift_en = 1'b0;
        clr      = 1'b0;
        ready    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        outs("rst", 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        outs("idle", 4'h0, 1'b0, 1'b0, 1'b0);

        // basic word 4'b1101, LSB first: 1,0,1,1
        ready = 1'b1;
        strobe(1'b1);
        chk("basic.busy1", {7'h0, busy}, 8'h1);
        strobe(1'b0);
        chk("basic.busy2", {7'h0, busy}, 8'h1);
        strobe(1'b1);
        outs("basic.b3", 4'h0, 1'b0, 1'b1, 1'b0);
        strobe(1'b1);
        outs("basic.done", 4'hD, 1'b1, 1'b0, 1'b0);
        tick();
        outs("basic.cons", 4'hD, 1'b0, 1'b0, 1'b0);

        // 4'hA with gaps: 0,1,0,1
        strobe(1'b0); tick();
        strobe(1'b1); tick(); tick();
        strobe(1'b0); tick();
        chk("gapA.pend", {7'h0, valid}, 8'h0);
        strobe(1'b1);
        outs("gapA.done", 4'hA, 1'b1, 1'b0, 1'b0);
        tick();
        outs("gapA.cons", 4'hA, 1'b0, 1'b0, 1'b0);
        // 4'h5: 1,0,1,0
        strobe(1'b1); tick();
        strobe(1'b0);
        strobe(1'b1); tick();
        strobe(1'b0);
        outs("gap5.done", 4'h5, 1'b1, 1'b0, 1'b0);
        tick();
        outs("gap5.cons", 4'h5, 1'b0, 1'b0, 1'b0);

        // overrun: 4'h3 then 4'h9 with ready low
        ready = 1'b0;
        strobe(1'b1); strobe(1'b1); strobe(1'b0); strobe(1'b0);
        outs("ovr.w1", 4'h3, 1'b1, 1'b0, 1'b0);
        strobe(1'b1); strobe(1'b0); strobe(1'b0); strobe(1'b1);
        outs("ovr.w2", 4'h3, 1'b1, 1'b0, 1'b1);
        ready = 1'b1;
        tick();
        outs("ovr.cons", 4'h3, 1'b0, 1'b0, 1'b1);

        // same-cycle handshake after reset clears overrun
        reset = 1'b1;
        tick();
        reset = 1'b0;
        outs("rst2", 4'h0, 1'b0, 1'b0, 1'b0);
        ready = 1'b0;
        strobe(1'b0); strobe(1'b1); strobe(1'b1); strobe(1'b0);
        outs("b2b.w6", 4'h6, 1'b1, 1'b0, 1'b0);
        strobe(1'b0); strobe(1'b0); strobe(1'b1);
        ready = 1'b1;
        strobe(1'b1);
        outs("b2b.wC", 4'hC, 1'b1, 1'b0, 1'b0);
        tick();
        outs("b2b.cons", 4'hC, 1'b0, 1'b0, 1'b0);

        // clr mid-word, strobe in the same cycle ignored
        strobe(1'b1); strobe(1'b1);
        chk("clr.pre", {7'h0, busy}, 8'h1);
        clr = 1'b1;
        strobe(1'b1);
        clr = 1'b0;
        outs("clr.post", 4'hC, 1'b0, 1'b0, 1'b0);
        strobe(1'b1); strobe(1'b1); strobe(1'b1); strobe(1'b0);
        outs("clr.w7", 4'h7, 1'b1, 1'b0, 1'b0);
        tick();
        chk("clr.cons", {7'h0, valid}, 8'h0);

        // reset mid-word
        strobe(1'b1); strobe(1'b0); strobe(1'b1);
        chk("rmid.pre", {7'h0, busy}, 8'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        outs("rmid.post", 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        outs("rmid.idle", 4'h0, 1'b0, 1'b0, 1'b0);
        strobe(1'b1);
        outs("rmid.b0", 4'h0, 1'b0, 1'b1, 1'b0);
        strobe(1'b0); strobe(1'b0); strobe(1'b0);
        outs("rmid.w1", 4'h1, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
